// File: rtl/mpu_alu_pipe.sv
// MPU match ALU: mask-match, masked-compare and unsigned less-than predicates on
// lane-selected operands, with chained AND accumulation and a stallable fixed-latency pipe.
module mpu_alu_pipe #(
  parameter int DW = 64,
  parameter int STAGES = 2,
  localparam int LW = $clog2(DW / 8)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [1:0]    in_size,
  input  logic          in_chain,
  input  logic          in_last,
  input  logic [DW-1:0] in_o0,
  input  logic [DW-1:0] in_o1,
  input  logic [DW-1:0] in_o2,
  input  logic [LW-1:0] in_s0,
  input  logic [LW-1:0] in_s1,
  input  logic [LW-1:0] in_s2,
  input  logic [LW-1:0] in_sres,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [7:0]    out_flags
);

  localparam logic [2:0] OP_MASK = 3'd1;
  localparam logic [2:0] OP_CMP  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;

  // A lane fits when its upper edge stays inside the datapath; this also rejects w > DW.
  function automatic logic lane_fits(input logic [1:0] size, input logic [LW-1:0] idx);
    logic [11:0] top;
    top = (12'(idx) + 12'd1) * (12'd8 << size);
    return top <= 12'(DW);
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [1:0] size);
    return ~({DW{1'b1}} << (12'd8 << size));
  endfunction

  function automatic logic [DW-1:0] lane_get(input logic [DW-1:0] v, input logic [1:0] size,
                                             input logic [LW-1:0] idx);
    return (v >> (12'(idx) * (12'd8 << size))) & lane_mask(size);
  endfunction

  logic [DW-1:0] a, b, c, wmask, res_d;
  logic [7:0]    flags_d;
  logic          legal, pred, upd, ok, act_new, accept;
  logic          acc, chain_act;

  logic [STAGES-1:0]         vld, adv;
  logic [STAGES-1:0][DW-1:0] res_q;
  logic [STAGES-1:0][7:0]    flg_q;

  always_comb begin
    wmask = lane_mask(in_size);
    a     = lane_get(in_o0, in_size, in_s0);
    b     = lane_get(in_o1, in_size, in_s1);
    c     = lane_get(in_o2, in_size, in_s2);
    legal = (in_op <= OP_LT) && lane_fits(in_size, in_s0) && lane_fits(in_size, in_s1)
            && lane_fits(in_size, in_s2);
    case (in_op)
      OP_MASK: pred = ((a & c) == c) && ((a & b) == '0) && ((b | c) == wmask);
      OP_CMP:  pred = ((a ^ b) & c) == '0;
      OP_LT:   pred = a < b;
      default: pred = 1'b1;
    endcase
    upd     = legal & in_chain;
    ok      = legal & (upd ? (acc & pred) : pred);
    act_new = upd ? !in_last : chain_act;
    res_d   = '0;
    if (ok && lane_fits(in_size, in_sres))
      res_d = DW'(1) << (12'(in_sres) * (12'd8 << in_size));
    flags_d = {5'b0, act_new, !legal, ok};
  end

  // A stage may move when it is empty or anything downstream of it can drain.
  always_comb begin
    adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = out_ready;
      for (int j = i; j < STAGES; j++)
        if (!vld[j]) adv[i] = 1'b1;
    end
  end

  assign in_ready  = !vld[STAGES-1] | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld[STAGES-1];
  assign out_res   = res_q[STAGES-1];
  assign out_flags = flg_q[STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld       <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      acc       <= 1'b1;
      chain_act <= 1'b0;
    end else begin
      if (accept && upd) begin
        acc       <= in_last | (acc & pred);
        chain_act <= !in_last;
      end
      if (adv[0]) begin
        vld[0] <= accept;
        if (accept) begin
          res_q[0] <= res_d;
          flg_q[0] <= flags_d;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            res_q[i] <= res_q[i-1];
            flg_q[i] <= flg_q[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_alu_pipe.sv
// Bench for mpu_alu_pipe: directed literal cases plus a randomized stream checked every
// cycle against a behavioural queue model of the predicates, chain accumulator and latency.
module tb_mpu_alu_pipe;
  localparam int DW = 64;
  localparam int STAGES = 2;
  localparam int LW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    in_op = '0;
  logic [1:0]    in_size = '0;
  logic          in_chain = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_o0 = '0, in_o1 = '0, in_o2 = '0;
  logic [LW-1:0] in_s0 = '0, in_s1 = '0, in_s2 = '0, in_sres = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_res;
  logic [7:0]    out_flags;

  always #5 sys_clk = ~sys_clk;

  mpu_alu_pipe #(.DW(DW), .STAGES(STAGES)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_chain(in_chain), .in_last(in_last),
    .in_o0(in_o0), .in_o1(in_o1), .in_o2(in_o2),
    .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .in_sres(in_sres),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] res;
    logic [7:0]  flags;
  } exp_t;

  exp_t q[$];
  bit   macc = 1'b1;
  bit   mact = 1'b0;

  function automatic int lane_w(input int size);
    return 8 << size;
  endfunction

  function automatic bit fits(input int size, input int idx);
    return (idx + 1) * lane_w(size) <= DW;
  endfunction

  function automatic logic [63:0] lane(input logic [63:0] x, input int size, input int idx);
    int w;
    logic [63:0] m;
    w = lane_w(size);
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (x >> (idx * w)) & m;
  endfunction

  task automatic model_accept();
    int sz;
    bit legal, pred, ok, act;
    logic [63:0] a, b, c, full, ones;
    exp_t e;
    sz = int'(in_size);
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    legal = (in_op <= 3) && fits(sz, int'(in_s0)) && fits(sz, int'(in_s1))
            && fits(sz, int'(in_s2));
    ok = 1'b0;
    act = mact;
    if (legal) begin
      a = lane(in_o0, sz, int'(in_s0));
      b = lane(in_o1, sz, int'(in_s1));
      c = lane(in_o2, sz, int'(in_s2));
      full = lane(ones, sz, 0);
      case (in_op)
        3'd1:    pred = ((a & c) == c) && ((a & b) == 64'd0) && ((b | c) == full);
        3'd2:    pred = ((a ^ b) & c) == 64'd0;
        3'd3:    pred = a < b;
        default: pred = 1'b1;
      endcase
      if (in_chain) begin
        ok = macc & pred;
        if (in_last) begin
          macc = 1'b1;
          mact = 1'b0;
        end else begin
          macc = macc & pred;
          mact = 1'b1;
        end
        act = mact;
      end else begin
        ok = pred;
      end
    end
    e.res = (ok && fits(sz, int'(in_sres))) ? (64'd1 << (int'(in_sres) * lane_w(sz))) : 64'd0;
    e.flags = {5'b0, act, ~legal, ok};
    q.push_back(e);
  endtask

  // ---------------- per-cycle compare, sampled 1 time unit before each rising edge ----------------
  bit          prev_stall = 1'b0;
  logic [63:0] prev_res;
  logic [7:0]  prev_flags;
  bit          acc_h[$];
  bit          rdy_h[$];

  initial begin
    bit accepted, all_rdy;
    forever begin
      @(negedge sys_clk);
      #4;
      if (!sys_rst_n) begin
        q.delete();
        macc = 1'b1;
        mact = 1'b0;
        acc_h.delete();
        rdy_h.delete();
        prev_stall = 1'b0;
        check("reset_out_valid", out_valid, 1'b0);
      end else begin
        check("in_ready_rule", in_ready, !out_valid | out_ready);
        if (prev_stall) begin
          check("stall_valid_hold", out_valid, 1'b1);
          check("stall_res_hold", out_res, prev_res);
          check("stall_flags_hold", out_flags, prev_flags);
        end
        if (acc_h.size() == STAGES) begin
          all_rdy = 1'b1;
          foreach (rdy_h[k]) if (!rdy_h[k]) all_rdy = 1'b0;
          if (all_rdy) check("latency_valid", out_valid, acc_h[STAGES-1]);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            fail_timeout("unexpected_output");
          end else begin
            check("model_res", out_res, q[0].res);
            check("model_flags", out_flags, q[0].flags);
            if (out_ready) void'(q.pop_front());
          end
        end
        accepted = in_valid && in_ready;
        if (accepted) model_accept();
        acc_h.push_front(accepted);
        rdy_h.push_front(out_ready);
        if (acc_h.size() > STAGES) begin
          void'(acc_h.pop_back());
          void'(rdy_h.pop_back());
        end
        prev_stall = out_valid && !out_ready;
        prev_res = out_res;
        prev_flags = out_flags;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv_pt();
    @(negedge sys_clk);
    #1;
  endtask

  // One beat with out_ready held high; literal expectations on the result and its latency.
  task automatic beat(input logic [2:0] op, input logic [1:0] size, input bit chain, input bit last,
                      input logic [63:0] o0, input logic [63:0] o1, input logic [63:0] o2,
                      input int s0, input int s1, input int s2, input int sres,
                      input logic [63:0] eres, input logic [7:0] eflags, input string name);
    bit got, found;
    int lat;
    drv_pt();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = op; in_size = size; in_chain = chain; in_last = last;
    in_o0 = o0; in_o1 = o1; in_o2 = o2;
    in_s0 = 3'(s0); in_s1 = 3'(s1); in_s2 = 3'(s2); in_sres = 3'(sres);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #3;
      got = in_ready;
      drv_pt();
    end
    in_valid = 1'b0;
    if (!got) begin
      fail_timeout({name, "_accept"});
    end else begin
      found = 1'b0;
      lat = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        #3;
        if (out_valid) begin
          found = 1'b1;
          lat = k;
          check({name, "_res"}, out_res, eres);
          check({name, "_flags"}, out_flags, {56'd0, eflags});
          check({name, "_latency"}, lat, STAGES - 1);
        end else begin
          drv_pt();
        end
      end
      if (!found) fail_timeout({name, "_output"});
    end
  endtask

  function automatic logic [2:0] pick_idx(input int size);
    if ($urandom_range(0, 7) == 0) return 3'($urandom_range(0, 7));
    return 3'($urandom_range(0, (64 >> (3 + size)) - 1));
  endfunction

  task automatic rand_beat();
    int mode;
    in_op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
    in_size = 2'($urandom_range(0, 3));
    in_s0 = pick_idx(int'(in_size));
    in_s1 = pick_idx(int'(in_size));
    in_s2 = pick_idx(int'(in_size));
    in_sres = pick_idx(int'(in_size));
    in_o0 = {$urandom, $urandom};
    in_o1 = {$urandom, $urandom};
    in_o2 = {$urandom, $urandom};
    mode = $urandom_range(0, 3);
    if (mode == 0) begin
      in_s1 = in_s0; in_s2 = in_s0;
      in_o2 = in_o0; in_o1 = ~in_o0;
    end else if (mode == 1) begin
      in_s1 = in_s0; in_o1 = in_o0;
    end
    in_chain = 1'($urandom_range(0, 1));
    in_last = in_chain & ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cur;
    bit took;
    // reset
    drv_pt();
    drv_pt();
    check("reset_valid", out_valid, 1'b0);
    check("reset_res", out_res, 64'd0);
    check("reset_flags", out_flags, 8'd0);
    sys_rst_n = 1'b1;
    #3;
    check("reset_in_ready", in_ready, 1'b1);

    // literal cases
    beat(3'd1, 2'd0, 0, 0, 64'h55, 64'hAA00, 64'h55_0000, 0, 1, 2, 3,
         64'h0000_0000_0100_0000, 8'h01, "mask_match");
    beat(3'd2, 2'd0, 0, 0, 64'h55, 64'h54, 64'hFF, 0, 0, 0, 0, 64'd0, 8'h00, "cmp_miss");
    beat(3'd2, 2'd0, 0, 0, 64'h55, 64'h54, 64'hFE, 0, 0, 0, 0, 64'd1, 8'h01, "cmp_masked");
    beat(3'd3, 2'd3, 0, 0, 64'h54, 64'h55, 64'd0, 0, 0, 0, 0, 64'd1, 8'h01, "lt_true");
    beat(3'd3, 2'd3, 0, 0, 64'h55, 64'h55, 64'd0, 0, 0, 0, 0, 64'd0, 8'h00, "lt_equal");
    beat(3'd3, 2'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 0, 0, 0, 0, 64'd0, 8'h00,
         "lt_unsigned");

    // chain: match, mismatch, match+last, then a fresh chain
    beat(3'd2, 2'd0, 1, 0, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h05, "chain1");
    beat(3'd2, 2'd0, 1, 0, 64'h55, 64'h54, 64'hFF, 0, 0, 0, 0, 64'd0, 8'h04, "chain2");
    beat(3'd2, 2'd0, 1, 1, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd0, 8'h00, "chain3");
    beat(3'd2, 2'd0, 1, 0, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h05, "chain_new");
    beat(3'd2, 2'd0, 1, 1, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h01, "chain_close");

    // illegal requests must not disturb the accumulator
    beat(3'd2, 2'd3, 0, 0, 64'h55, 64'h55, 64'hFF, 1, 0, 0, 0, 64'd0, 8'h02, "illegal_lane");
    beat(3'd5, 2'd0, 0, 0, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd0, 8'h02, "illegal_op");
    beat(3'd2, 2'd0, 1, 0, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h05, "ill_open");
    beat(3'd2, 2'd3, 1, 0, 64'h55, 64'h55, 64'hFF, 1, 0, 0, 0, 64'd0, 8'h06, "ill_chained");
    beat(3'd2, 2'd0, 1, 1, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h01, "ill_acc_kept");

    // reset mid-chain with a beat in flight
    beat(3'd2, 2'd0, 1, 0, 64'h55, 64'h54, 64'hFF, 0, 0, 0, 0, 64'd0, 8'h04, "rst_open");
    drv_pt();
    in_valid = 1'b1; in_op = 3'd2; in_chain = 1'b0; in_last = 1'b0;
    drv_pt();
    in_valid = 1'b0;
    drv_pt();
    check("rst_inflight_valid", out_valid, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_flags", out_flags, 8'd0);
    drv_pt();
    drv_pt();
    sys_rst_n = 1'b1;
    beat(3'd2, 2'd0, 1, 1, 64'h55, 64'h55, 64'hFF, 0, 0, 0, 0, 64'd1, 8'h01, "rst_acc_one");

    // backpressure: 8 LT beats with out_ready 1,0,0,1 repeating
    sent = 0;
    cur = -1;
    for (int c = 0; c < 200 && (sent < 8 || q.size() != 0); c++) begin
      drv_pt();
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (sent < 8) begin
        in_valid = 1'b1;
        if (cur != sent) begin
          cur = sent;
          in_op = 3'd3; in_chain = 1'b0; in_last = 1'b0;
          in_size = 2'($urandom_range(0, 3));
          in_s0 = 3'($urandom_range(0, (64 >> (3 + int'(in_size))) - 1));
          in_s1 = 3'($urandom_range(0, (64 >> (3 + int'(in_size))) - 1));
          in_s2 = 3'd0;
          in_sres = 3'($urandom_range(0, (64 >> (3 + int'(in_size))) - 1));
          in_o0 = {$urandom, $urandom};
          in_o1 = {$urandom, $urandom};
        end
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (in_valid && in_ready) sent++;
    end
    drv_pt();
    in_valid = 1'b0;
    check("bp_sent", sent, 8);
    check("bp_drained", q.size(), 0);

    // randomized stream
    took = 1'b0;
    for (int c = 0; c < 600; c++) begin
      drv_pt();
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 7);
        if (in_valid) rand_beat();
      end
      #3;
      took = in_valid && in_ready;
    end
    drv_pt();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) drv_pt();
    check("final_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_alu_pipe.md
# mpu_alu_pipe

Pipelined, parametrised successor to the MPU match ALU. It evaluates mask-match, masked-compare and unsigned less-than predicates on lane-selected operands, with a valid/ready handshake on both sides and a configurable fixed latency. A chain mode AND-accumulates predicates across multi-beat sequences, so wide keys can be matched over several beats. It sits between the MPU decode stage and the MPU result/branch logic.

## Interface
- DW, 64: datapath width in bits; power of two, 16..128.
- STAGES, 2: pipeline depth, 1..4; equals latency in cycles.
- LW = log2(DW/8): lane-select width (derived).
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted this cycle when in_valid & in_ready.
- in_op  in  3  0 NOP, 1 MASK, 2 CMP, 3 LT, 4..7 reserved.
- in_size  in  2  lane width: 0=8, 1=16, 2=32, 3=64 bits.
- in_chain  in  1  AND this beat's predicate into the chain accumulator.
- in_last  in  1  final beat of a chain; clears the accumulator after use.
- in_o0, in_o1, in_o2  in  DW  operands a, b/m0, mask/m1.
- in_s0, in_s1, in_s2, in_sres  in  LW  lane index in units of the lane width.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  DW  result word.
- out_flags  out  8  [0] ok, [1] illegal, [2] chain_active, [7:3] zero.

## Operation
- Lane extraction: lane x = in_oN[idx*w +: w], where w = 8<<in_size. Bits above w are ignored.
- Illegal request: w > DW, or idx*w + w > DW, or a reserved op.
  - Forces ok=0 and illegal=1.
  - Does not update the accumulator.
- MASK (a=o0@s0, m0=o1@s1, m1=o2@s2): ok iff (a & m1)==m1 and (a & m0)==0 and (m0|m1) is all ones over w.
- CMP: ok iff ((a ^ b) & mask)==0, with a=o0@s0, b=o1@s1, mask=o2@s2.
- LT: ok iff a < b, unsigned, over w bits.
- NOP: ok=1, illegal=0.
- Chain accumulator acc, reset value 1:
  - On acceptance with in_chain=1: reported ok = acc & pred.
  - Then acc <= pred & acc, or acc <= 1 if in_last=1.
  - in_chain=0: reported ok = pred, and acc is untouched.
  - chain_active = 1 when acc has absorbed at least one beat and no in_last has been seen yet; this is evaluated after the beat's update.
- out_res: zero except lane sres (width w), which holds 1 when ok, else 0. An illegal sres gives out_res = 0.
- Predicate, accumulator update and chain_active are computed at acceptance and registered in stage 1. Stages 2..STAGES are plain delay registers.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - Stage valids = 0, so out_valid = 0.
  - out_res = 0, out_flags = 0, acc = 1.
  - in_ready = 1 from the first cycle after reset release.
- Latency: a beat accepted at edge k appears at out_valid after edge k+STAGES-1, provided out_ready stayed 1.
- Throughput: one beat per cycle.
- Stall: in_ready = !out_valid | out_ready.
  - When out_valid & !out_ready, all stages hold.
  - out_res and out_flags stay stable while stalled.
  - in_ready drops in the same cycle, combinationally from out_ready.
- Pipeline bubbles are squeezed: a stage with valid=0 advances even while later stages hold.
- Acceptance and output on the same edge are both honoured, and ordering is preserved.
- Back-to-back chains: a beat with in_last=1 followed immediately by a chained beat starts the new chain with acc=1.
- Reset mid-chain or mid-pipeline: in-flight beats are discarded and acc returns to 1.

## Test plan
- DW=64, STAGES=2, size=0, op=MASK, o0[7:0]=0x55, o1[15:8]=0xAA, o2[23:16]=0x55, s0/s1/s2 = 0/1/2, sres=3 -> two cycles later out_valid=1, out_res=0x0000_0000_0100_0000, flags=0x01.
- CMP with size=0, lanes 0, a=0x55: b=0x54, mask=0xFF -> ok=0; same with mask=0xFE -> ok=1, out_res[7:0]=0x01.
- LT with size=3: a=0x54, b=0x55 -> ok=1; a=b=0x55 -> ok=0; a=0xFF..FF, b=0 -> ok=0 (unsigned).
- Chain of three CMP beats, second mismatching, third in_last=1:
  - Reported ok is 1, 0, 0 and chain_active is 1, 1, 0.
  - A following chained matching beat reports ok=1.
- Backpressure: stream 8 LT beats with out_ready toggled 1,0,0,1,...
  - No loss or duplication, order preserved.
  - Outputs stable while stalled.
  - in_ready = 0 exactly when out_valid & !out_ready.
- Illegal handling and reset:
  - size=3, s0=1 on DW=64 -> flags=0x02, out_res=0, acc unchanged.
  - sys_rst_n pulsed low mid-stream -> out_valid=0 immediately; acc=1 afterwards.
